rs_issue_sched: RTL and testbench

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

---
 rtl/rs_issue_sched.sv | 152 +++++++++++++++
 tb/tb_rs_issue_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: allocates free RS lines to dispatch ways and
// issues the oldest ready lines to functional units, tracking age with an older-matrix.
module rs_issue_sched #(
  parameter int RS   = 16,
  parameter int WAYS = 3,
  localparam int IW  = (RS > 1) ? $clog2(RS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [RS-1:0]            line_free_i,
  input  logic [RS-1:0]            line_ready_i,
  input  logic [WAYS-1:0]          dispatch_req_i,
  input  logic [WAYS-1:0]          fu_ready_i,
  input  logic                     squash_i,
  output logic [RS-1:0]            load_en_o,
  output logic [WAYS-1:0]          dispatch_ack_o,
  output logic [RS-1:0]            line_clear_o,
  output logic [WAYS-1:0]          issue_valid_o,
  output logic [WAYS-1:0][IW-1:0]  issue_idx_o
);

  logic [RS-1:0]             occ_q, occ_d;
  logic [RS-1:0][RS-1:0]     older_q, older_d;
  logic [RS-1:0][RS-1:0]     older_t;
  logic [WAYS-1:0]           issue_valid_q, issue_valid_d;
  logic [WAYS-1:0][IW-1:0]   issue_idx_q, issue_idx_d;

  logic                      active;
  logic [RS-1:0]             remaining, oldest, clear_s;
  logic [WAYS-1:0][RS-1:0]   grant_oh;
  logic [WAYS-1:0]           grant_vld;

  logic [RS-1:0]             avail, pick, load_s;
  logic [WAYS-1:0][RS-1:0]   alloc_oh;
  logic [WAYS-1:0]           ack_s;
  logic [RS-1:0]             prior;

  function automatic logic [IW-1:0] enc(input logic [RS-1:0] oh);
    enc = '0;
    for (int i = 0; i < RS; i++) begin
      if (oh[i]) enc = enc | IW'(i);
    end
  endfunction

  // older_t[i][j] = older_q[j][i]: set bits are lines older than line i
  always_comb begin
    older_t = '0;
    for (int i = 0; i < RS; i++) begin
      for (int j = 0; j < RS; j++) begin
        older_t[i][j] = older_q[j][i];
      end
    end
  end

  assign active = rst_ni & ~squash_i;

  // Selection: each ready FU in ascending order takes the oldest remaining candidate
  always_comb begin
    remaining = occ_q & line_ready_i;
    oldest    = '0;
    clear_s   = '0;
    grant_oh  = '0;
    grant_vld = '0;
    for (int k = 0; k < WAYS; k++) begin
      oldest = '0;
      if (active && fu_ready_i[k]) begin
        for (int i = 0; i < RS; i++) begin
          oldest[i] = remaining[i] & ~(|(older_t[i] & remaining));
        end
        // Lowest-index tie-break keeps the grant one-hot even on a malformed matrix
        oldest       = oldest & (~oldest + RS'(1));
        grant_oh[k]  = oldest;
        grant_vld[k] = |oldest;
        remaining    = remaining & ~oldest;
        clear_s      = clear_s | oldest;
      end
    end
  end

  // Allocation: way k takes the k-th lowest free line not being cleared this cycle
  always_comb begin
    avail    = line_free_i & ~clear_s;
    pick     = '0;
    load_s   = '0;
    alloc_oh = '0;
    ack_s    = '0;
    for (int k = 0; k < WAYS; k++) begin
      pick     = avail & (~avail + RS'(1));
      ack_s[k] = active & dispatch_req_i[k] & (|pick);
      if (ack_s[k]) begin
        alloc_oh[k] = pick;
        load_s      = load_s | pick;
      end
      avail = avail & ~pick;
    end
  end

  assign load_en_o      = load_s;
  assign dispatch_ack_o = ack_s;
  assign line_clear_o   = clear_s;
  assign issue_valid_o  = issue_valid_q;
  assign issue_idx_o    = issue_idx_q;

  always_comb begin
    occ_d   = (occ_q & ~clear_s) | load_s;
    older_d = older_q;
    prior   = occ_q & ~clear_s;
    for (int i = 0; i < RS; i++) begin
      if (clear_s[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < RS; j++) older_d[j][i] = 1'b0;
      end
    end
    // A newly loaded line is younger than every surviving line and every lower way
    for (int k = 0; k < WAYS; k++) begin
      for (int i = 0; i < RS; i++) begin
        if (alloc_oh[k][i]) begin
          older_d[i] = '0;
          for (int j = 0; j < RS; j++) older_d[j][i] = prior[j] && (j != i);
        end
      end
      prior = prior | alloc_oh[k];
    end
    if (squash_i) begin
      occ_d   = '0;
      older_d = '0;
    end
  end

  always_comb begin
    issue_valid_d = grant_vld;
    issue_idx_d   = issue_idx_q;
    for (int k = 0; k < WAYS; k++) begin
      if (grant_vld[k]) issue_idx_d[k] = enc(grant_oh[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q         <= '0;
      older_q       <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
    end else begin
      occ_q         <= occ_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: combinational strobes checked mid-cycle,
// issue outputs checked after each edge against a scoreboard queue.
module tb_rs_issue_sched;
  localparam int RS   = 16;
  localparam int WAYS = 3;
  localparam int IW   = 4;
  localparam int EW   = WAYS + WAYS * IW;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [RS-1:0]            line_free, line_ready;
  logic [WAYS-1:0]          dispatch_req, fu_ready;
  logic                     squash;
  logic [RS-1:0]            load_en, line_clear;
  logic [WAYS-1:0]          dispatch_ack, issue_valid;
  logic [WAYS-1:0][IW-1:0]  issue_idx;

  logic [EW-1:0]            exp_q[$];
  logic [IW-1:0]            model_idx [WAYS];
  int                       pass_cnt  = 0;
  int                       total_cnt = 0;

  always #5 clk = ~clk;

  rs_issue_sched #(.RS(RS), .WAYS(WAYS)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .line_free_i    (line_free),
    .line_ready_i   (line_ready),
    .dispatch_req_i (dispatch_req),
    .fu_ready_i     (fu_ready),
    .squash_i       (squash),
    .load_en_o      (load_en),
    .dispatch_ack_o (dispatch_ack),
    .line_clear_o   (line_clear),
    .issue_valid_o  (issue_valid),
    .issue_idx_o    (issue_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [RS-1:0] free, input logic [RS-1:0] ready,
                       input logic [WAYS-1:0] req, input logic [WAYS-1:0] fu,
                       input logic sq);
    line_free    = free;
    line_ready   = ready;
    dispatch_req = req;
    fu_ready     = fu;
    squash       = sq;
  endtask

  task automatic push_exp(input logic [WAYS-1:0] v, input logic [IW-1:0] i0,
                          input logic [IW-1:0] i1, input logic [IW-1:0] i2);
    if (v[0]) model_idx[0] = i0;
    if (v[1]) model_idx[1] = i1;
    if (v[2]) model_idx[2] = i2;
    exp_q.push_back({v, model_idx[2], model_idx[1], model_idx[0]});
  endtask

  task automatic pop_check(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(issue_valid), 32'(e[EW-1 -: WAYS]));
      check({tag, "_idx"},   32'(issue_idx),   32'(e[WAYS*IW-1:0]));
    end
  endtask

  task automatic comb_check(input string tag, input logic [RS-1:0] ld,
                            input logic [WAYS-1:0] ack, input logic [RS-1:0] clr);
    @(negedge clk);
    check({tag, "_load_en"},  32'(load_en),      32'(ld));
    check({tag, "_ack"},      32'(dispatch_ack), 32'(ack));
    check({tag, "_clear"},    32'(line_clear),   32'(clr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < WAYS; k++) model_idx[k] = '0;
    drive(16'hFFFF, 16'hFFFF, 3'b111, 3'b111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    comb_check("in_reset", 16'h0000, 3'b000, 16'h0000);
    check("rst_valid", 32'(issue_valid), 32'h0);
    check("rst_idx",   32'(issue_idx),   32'h0);
    step();

    // Three-wide dispatch into an empty station, then three-wide issue
    rst_n = 1'b1;
    drive(16'hFFFF, 16'h0000, 3'b111, 3'b000, 1'b0);
    comb_check("fill", 16'h0007, 3'b111, 16'h0000);
    step();
    drive(16'hFFF8, 16'h0007, 3'b000, 3'b111, 1'b0);
    comb_check("fill_sel", 16'h0000, 3'b000, 16'h0007);
    push_exp(3'b111, 4'd0, 4'd1, 4'd2);
    step();
    pop_check("fill_issue");
    drive(16'hFFFF, 16'h0000, 3'b000, 3'b000, 1'b0);
    comb_check("idle", 16'h0000, 3'b000, 16'h0000);
    push_exp(3'b000, 4'd0, 4'd0, 4'd0);
    step();
    pop_check("idle_hold");

    // Age order beats index order; a just-loaded line is not selectable
    drive(16'hFFE0, 16'h0020, 3'b001, 3'b001, 1'b0);
    comb_check("load5", 16'h0020, 3'b001, 16'h0000);
    step();
    drive(16'h0004, 16'h0000, 3'b001, 3'b000, 1'b0);
    comb_check("load2", 16'h0004, 3'b001, 16'h0000);
    step();
    drive(16'h0000, 16'h0024, 3'b000, 3'b001, 1'b0);
    comb_check("age_a", 16'h0000, 3'b000, 16'h0020);
    push_exp(3'b001, 4'd5, 4'd0, 4'd0);
    step();
    pop_check("age_first");
    drive(16'h0000, 16'h0004, 3'b000, 3'b001, 1'b0);
    comb_check("age_b", 16'h0000, 3'b000, 16'h0004);
    push_exp(3'b001, 4'd2, 4'd0, 4'd0);
    step();
    pop_check("age_second");

    // Partial acceptance at the top of the station, then squash
    drive(16'hC000, 16'h0000, 3'b111, 3'b000, 1'b0);
    comb_check("partial", 16'hC000, 3'b011, 16'h0000);
    step();
    drive(16'hFFFF, 16'hC000, 3'b111, 3'b111, 1'b1);
    comb_check("squash", 16'h0000, 3'b000, 16'h0000);
    push_exp(3'b000, 4'd0, 4'd0, 4'd0);
    step();
    pop_check("squash_issue");
    drive(16'h0008, 16'hC000, 3'b001, 3'b001, 1'b0);
    comb_check("post_squash", 16'h0008, 3'b001, 16'h0000);
    step();
    drive(16'h0000, 16'hC008, 3'b000, 3'b111, 1'b0);
    comb_check("post_squash_sel", 16'h0000, 3'b000, 16'h0008);
    push_exp(3'b001, 4'd3, 4'd0, 4'd0);
    step();
    pop_check("post_squash_issue");

    // Four lines aged 8,4,10,11; FU1 not ready, then leftovers
    drive(16'h0100, 16'h0000, 3'b001, 3'b000, 1'b0);
    step();
    drive(16'h0010, 16'h0000, 3'b001, 3'b000, 1'b0);
    step();
    drive(16'h0C00, 16'h0000, 3'b011, 3'b000, 1'b0);
    comb_check("load_pair", 16'h0C00, 3'b011, 16'h0000);
    step();
    drive(16'h0000, 16'h0D10, 3'b000, 3'b101, 1'b0);
    comb_check("sel101", 16'h0000, 3'b000, 16'h0110);
    push_exp(3'b101, 4'd8, 4'd0, 4'd4);
    step();
    pop_check("issue101");
    drive(16'h0000, 16'h0C00, 3'b000, 3'b111, 1'b0);
    comb_check("sel_rest", 16'h0000, 3'b000, 16'h0C00);
    push_exp(3'b011, 4'd10, 4'd11, 4'd0);
    step();
    pop_check("issue_rest");

    // Asynchronous reset between edges while all FUs hold valid issues
    drive(16'h0007, 16'h0000, 3'b111, 3'b000, 1'b0);
    step();
    drive(16'h0000, 16'h0007, 3'b000, 3'b111, 1'b0);
    comb_check("pre_rst_sel", 16'h0000, 3'b000, 16'h0007);
    push_exp(3'b111, 4'd0, 4'd1, 4'd2);
    step();
    pop_check("pre_rst_issue");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(issue_valid), 32'h0);
    check("async_rst_idx",   32'(issue_idx),   32'h0);
    for (int k = 0; k < WAYS; k++) model_idx[k] = '0;
    drive(16'hFFFF, 16'hFFFF, 3'b111, 3'b111, 1'b0);
    comb_check("rst_low", 16'h0000, 3'b000, 16'h0000);
    step();
    rst_n = 1'b1;
    drive(16'h0001, 16'hFFFF, 3'b001, 3'b111, 1'b0);
    comb_check("after_rst", 16'h0001, 3'b001, 16'h0000);
    push_exp(3'b000, 4'd0, 4'd0, 4'd0);
    step();
    pop_check("after_rst_issue");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
